// File: rtl/nn_pkg.sv
// Shared types and width helpers for the NN training front-end.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Default geometry of the training core
  localparam int DEF_SIG_W       = 23;
  localparam int DEF_EXP_W       = 8;
  localparam int DEF_N_IN        = 4;
  localparam int DEF_N_HID       = 3;
  localparam int DEF_EPOCH_MAX   = 25;
  localparam int DEF_DATASET_MAX = 100;

  // Index width that never collapses to zero bits for tiny ranges
  function automatic int clog2_min1(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

  // Float word width: sign + exponent + significand
  function automatic int float_dw(input int sig_w, input int exp_w);
    return sig_w + exp_w + 1;
  endfunction

endpackage

// File: rtl/nn_sample_buf.sv
// One sample slot: N_IN data words plus one target, filled word-by-word
// (staging) or copied whole from another slot (active).
module nn_sample_buf
  import nn_pkg::*;
#(
  parameter int DW   = 32,
  parameter int N_IN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    wr_d,
  input  logic [DW-1:0]           word_d,
  input  logic                    wr_t,
  input  logic [DW-1:0]           word_t,
  input  logic                    ld,
  input  logic [N_IN-1:0][DW-1:0] ld_data,
  input  logic [DW-1:0]           ld_tgt,
  output logic [N_IN-1:0][DW-1:0] data,
  output logic [DW-1:0]           tgt,
  output logic                    full
);

  localparam int CW = clog2_min1(N_IN + 1);

  logic [CW-1:0] cnt;
  logic          has_tgt;
  logic          data_full;

  assign data_full = (cnt == CW'(N_IN));
  assign full      = data_full && has_tgt;

  // Slot contents: clear wins over whole-copy, which wins over word writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= '0;
      tgt     <= '0;
      cnt     <= '0;
      has_tgt <= 1'b0;
    end else if (clr) begin
      data    <= '0;
      tgt     <= '0;
      cnt     <= '0;
      has_tgt <= 1'b0;
    end else if (ld) begin
      data    <= ld_data;
      tgt     <= ld_tgt;
      cnt     <= CW'(N_IN);
      has_tgt <= 1'b1;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (wr_d && !data_full && (cnt == CW'(i))) data[i] <= word_d;
      end
      if (wr_d && !data_full) cnt <= cnt + CW'(1);
      // target is taken once; later target strobes for the same sample are ignored
      if (wr_t && !has_tgt) begin
        tgt     <= word_t;
        has_tgt <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/nn_train_sequencer.sv
// Front-end for the NN training core: weight load, double-buffered sample
// issue over valid/ready, weight write-back and dataset/epoch tracking.
module nn_train_sequencer
  import nn_pkg::*;
#(
  parameter  int SIG_W       = DEF_SIG_W,
  parameter  int EXP_W       = DEF_EXP_W,
  parameter  int N_IN        = DEF_N_IN,
  parameter  int N_HID       = DEF_N_HID,
  parameter  int EPOCH_MAX   = DEF_EPOCH_MAX,
  parameter  int DATASET_MAX = DEF_DATASET_MAX,
  localparam int DW          = float_dw(SIG_W, EXP_W),
  localparam int DIW         = clog2_min1(DATASET_MAX),
  localparam int EIW         = clog2_min1(EPOCH_MAX)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid_w1,
  input  logic [DW-1:0]             weight1,
  input  logic                      in_valid_w2,
  input  logic [DW-1:0]             weight2,
  input  logic                      in_valid_d,
  input  logic [DW-1:0]             data_point,
  input  logic                      in_valid_t,
  input  logic [DW-1:0]             target,
  output logic                      smp_valid,
  input  logic                      smp_ready,
  output logic [N_IN*DW-1:0]        smp_data,
  output logic [DW-1:0]             smp_target,
  output logic [N_HID*N_IN*DW-1:0]  w1_flat,
  output logic [N_HID*DW-1:0]       w2_flat,
  input  logic                      upd_valid,
  input  logic [N_HID*N_IN*DW-1:0]  upd_w1,
  input  logic [N_HID*DW-1:0]       upd_w2,
  output logic [DIW-1:0]            data_idx,
  output logic [EIW-1:0]            epoch_idx,
  output logic                      train_done,
  output logic                      err
);

  localparam int W1_N = N_HID * N_IN;
  localparam int W2_N = N_HID;
  localparam int C1W  = clog2_min1(W1_N + 1);
  localparam int C2W  = clog2_min1(W2_N + 1);

  state_t state, state_nx;

  logic [C1W-1:0]           w1_cnt;
  logic [C2W-1:0]           w2_cnt;
  logic [W1_N-1:0][DW-1:0]  w1_q;
  logic [W2_N-1:0][DW-1:0]  w2_q;

  logic [N_IN-1:0][DW-1:0]  stg_data, act_data;
  logic [DW-1:0]            stg_tgt, act_tgt;
  logic                     stg_full, act_full;
  logic                     acc_q;

  logic w1_done, w2_done, w_open, w1_wr, w2_wr;
  logic ld_open, d_wr, t_wr, xfer, accept, outstanding, upd;
  logic last_smp, flush, err_set;

  // ---- weight load stream ----
  assign w1_done = (w1_cnt == C1W'(W1_N));
  assign w2_done = (w2_cnt == C2W'(W2_N));
  assign w_open  = (state == IDLE) || (state == LOAD_W);
  assign w1_wr   = in_valid_w1 && w_open && !w1_done;
  assign w2_wr   = in_valid_w2 && w_open && !w2_done;

  // ---- sample path ----
  assign ld_open     = (state == LOAD_W) || (state == RUN);
  assign d_wr        = in_valid_d && ld_open && !stg_full;
  assign t_wr        = in_valid_t && ld_open && !stg_full;
  // Uses the registered active-full flag, so a transfer that coincides with
  // the freeing update naturally slips one cycle.
  assign xfer        = (state == RUN) && stg_full && !act_full;
  assign accept      = smp_valid && smp_ready;
  assign outstanding = acc_q || accept;
  assign upd         = upd_valid && outstanding;
  assign last_smp    = (data_idx == DIW'(DATASET_MAX - 1)) &&
                       (epoch_idx == EIW'(EPOCH_MAX - 1));
  assign flush       = (state == DONE);

  assign err_set = (in_valid_w1 && !w1_wr) ||
                   (in_valid_w2 && !w2_wr) ||
                   (ld_open && stg_full && (in_valid_d || in_valid_t)) ||
                   (upd_valid && !outstanding) ||
                   (in_valid_d && (state == IDLE));

  nn_sample_buf #(.DW(DW), .N_IN(N_IN)) u_stg (
    .clk     (clk),
    .rst     (rst),
    .clr     (xfer || flush),
    .wr_d    (d_wr),
    .word_d  (data_point),
    .wr_t    (t_wr),
    .word_t  (target),
    .ld      (1'b0),
    .ld_data ('0),
    .ld_tgt  ('0),
    .data    (stg_data),
    .tgt     (stg_tgt),
    .full    (stg_full)
  );

  nn_sample_buf #(.DW(DW), .N_IN(N_IN)) u_act (
    .clk     (clk),
    .rst     (rst),
    .clr     (upd || flush),
    .wr_d    (1'b0),
    .word_d  ('0),
    .wr_t    (1'b0),
    .word_t  ('0),
    .ld      (xfer),
    .ld_data (stg_data),
    .ld_tgt  (stg_tgt),
    .data    (act_data),
    .tgt     (act_tgt),
    .full    (act_full)
  );

  assign smp_data   = act_data;
  assign smp_target = act_tgt;
  assign w1_flat    = w1_q;
  assign w2_flat    = w2_q;
  assign train_done = (state == DONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: weight load, then the issue/update loop until the last sample
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid_w1 || in_valid_w2) state_nx = LOAD_W;
      LOAD_W:  if (w1_done && w2_done)         state_nx = RUN;
      RUN:     if (upd && last_smp)            state_nx = DONE;
      DONE:                                    state_nx = IDLE;
      default:                                 state_nx = IDLE;
    endcase
  end

  // Weight load counters; rearmed when a training run finishes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w1_cnt <= '0;
      w2_cnt <= '0;
    end else if (flush) begin
      w1_cnt <= '0;
      w2_cnt <= '0;
    end else begin
      if (w1_wr) w1_cnt <= w1_cnt + C1W'(1);
      if (w2_wr) w2_cnt <= w2_cnt + C2W'(1);
    end
  end

  // Weight arrays: streamed in word by word, or replaced whole by write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w1_q <= '0;
      w2_q <= '0;
    end else if (upd) begin
      w1_q <= upd_w1;
      w2_q <= upd_w2;
    end else begin
      for (int i = 0; i < W1_N; i++)
        if (w1_wr && (w1_cnt == C1W'(i))) w1_q[i] <= weight1;
      for (int i = 0; i < W2_N; i++)
        if (w2_wr && (w2_cnt == C2W'(i))) w2_q[i] <= weight2;
    end
  end

  // Handshake: valid from transfer to acceptance, then wait for write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_valid <= 1'b0;
      acc_q     <= 1'b0;
    end else if (flush) begin
      smp_valid <= 1'b0;
      acc_q     <= 1'b0;
    end else begin
      if (xfer)        smp_valid <= 1'b1;
      else if (accept) smp_valid <= 1'b0;
      if (upd)         acc_q <= 1'b0;
      else if (accept) acc_q <= 1'b1;
    end
  end

  // Dataset / epoch position, advanced by each accepted write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_idx  <= '0;
      epoch_idx <= '0;
    end else if (flush) begin
      data_idx  <= '0;
      epoch_idx <= '0;
    end else if (upd) begin
      if (data_idx == DIW'(DATASET_MAX - 1)) begin
        data_idx  <= '0;
        epoch_idx <= (epoch_idx == EIW'(EPOCH_MAX - 1)) ? '0 : epoch_idx + EIW'(1);
      end else begin
        data_idx  <= data_idx + DIW'(1);
      end
    end
  end

  // Sticky protocol error
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

endmodule

// File: tb/tb_nn_train_sequencer.sv
// Randomized self-checking bench for nn_train_sequencer (small dataset/epochs).
module tb_nn_train_sequencer;

  localparam int SIG_W = 23;
  localparam int EXP_W = 8;
  localparam int DW    = 32;
  localparam int N_IN  = 4;
  localparam int N_HID = 3;
  localparam int EP    = 2;
  localparam int DS    = 3;
  localparam int W1_N  = N_HID * N_IN;
  localparam int W2_N  = N_HID;
  localparam int DIW   = 2;
  localparam int EIW   = 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid_w1, in_valid_w2, in_valid_d, in_valid_t;
  logic [DW-1:0]        weight1, weight2, data_point, target;
  logic                 smp_valid, smp_ready;
  logic [N_IN*DW-1:0]   smp_data;
  logic [DW-1:0]        smp_target;
  logic [W1_N*DW-1:0]   w1_flat, upd_w1;
  logic [W2_N*DW-1:0]   w2_flat, upd_w2;
  logic                 upd_valid;
  logic [DIW-1:0]       data_idx;
  logic [EIW-1:0]       epoch_idx;
  logic                 train_done, err;

  always #5 clk = ~clk;

  nn_train_sequencer #(
    .SIG_W(SIG_W), .EXP_W(EXP_W), .N_IN(N_IN), .N_HID(N_HID),
    .EPOCH_MAX(EP), .DATASET_MAX(DS)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid_w1(in_valid_w1), .weight1(weight1),
    .in_valid_w2(in_valid_w2), .weight2(weight2),
    .in_valid_d(in_valid_d), .data_point(data_point),
    .in_valid_t(in_valid_t), .target(target),
    .smp_valid(smp_valid), .smp_ready(smp_ready),
    .smp_data(smp_data), .smp_target(smp_target),
    .w1_flat(w1_flat), .w2_flat(w2_flat),
    .upd_valid(upd_valid), .upd_w1(upd_w1), .upd_w2(upd_w2),
    .data_idx(data_idx), .epoch_idx(epoch_idx),
    .train_done(train_done), .err(err)
  );

  typedef struct {
    logic [N_IN-1:0][DW-1:0] d;
    logic [DW-1:0]           t;
  } smp_t;

  // reference model: expected weights, samples in order, update count
  logic [W1_N-1:0][DW-1:0] mw1, nw1;
  logic [W2_N-1:0][DW-1:0] mw2, nw2;
  smp_t                    q[$];
  int                      n_upd;
  int                      n_chk = 0;
  int                      n_err = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic smp_t rand_smp();
    smp_t s;
    for (int i = 0; i < N_IN; i++) s.d[i] = $urandom;
    s.t = $urandom;
    return s;
  endfunction

  // both weight streams with random gaps and overlap
  task automatic load_weights(input bit ramp);
    int i1 = 0;
    int i2 = 0;
    int guard = 0;
    while ((i1 < W1_N || i2 < W2_N) && guard < 500) begin
      in_valid_w1 = (i1 < W1_N) && ($urandom_range(0, 3) != 0);
      in_valid_w2 = (i2 < W2_N) && ($urandom_range(0, 2) == 0);
      if (in_valid_w1) begin
        weight1 = ramp ? 32'h3F800000 + i1 : $urandom;
        mw1[i1] = weight1;
      end
      if (in_valid_w2) begin
        weight2 = ramp ? 32'h3F000000 + i2 : $urandom;
        mw2[i2] = weight2;
      end
      tick();
      if (in_valid_w1) i1++;
      if (in_valid_w2) i2++;
      guard++;
    end
    in_valid_w1 = 1'b0;
    in_valid_w2 = 1'b0;
    repeat (3) tick();
  endtask

  // data words back to back; target alongside word tpos, or after them when tpos==N_IN
  task automatic load_sample(input smp_t s, input int tpos);
    int nc = (tpos >= N_IN) ? N_IN + 1 : N_IN;
    for (int c = 0; c < nc; c++) begin
      in_valid_d = (c < N_IN);
      if (c < N_IN) data_point = s.d[c];
      in_valid_t = (c == tpos);
      target     = s.t;
      tick();
    end
    in_valid_d = 1'b0;
    in_valid_t = 1'b0;
    q.push_back(s);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!smp_valid && n < 40) begin
      tick();
      n++;
    end
    chk("smp_valid_wait", smp_valid, 1'b1);
  endtask

  task automatic pulse_upd();
    for (int i = 0; i < W1_N; i++) nw1[i] = $urandom;
    for (int i = 0; i < W2_N; i++) nw2[i] = $urandom;
    upd_w1    = nw1;
    upd_w2    = nw2;
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
  endtask

  // model after a write-back: weights replaced, sample retired, position advanced
  task automatic post_upd();
    smp_t s;
    s = q.pop_front();
    mw1 = nw1;
    mw2 = nw2;
    n_upd++;
    chk("w1_upd", w1_flat, mw1);
    chk("w2_upd", w2_flat, mw2);
    chk("done_pulse", train_done, (n_upd == DS * EP));
    chk("data_idx_upd", data_idx, n_upd % DS);
    if (n_upd < DS * EP) chk("epoch_upd", epoch_idx, n_upd / DS);
    if (n_upd == DS * EP) begin
      tick();
      chk("done_single", train_done, 1'b0);
      n_upd = 0;
    end
  endtask

  // hold off rdly cycles, accept, then write back udly cycles later (0 = same cycle)
  task automatic accept_update(input int rdly, input int udly);
    smp_ready = 1'b0;
    repeat (rdly) tick();
    chk("hold_data", smp_data, q[0].d);
    chk("hold_tgt", smp_target, q[0].t);
    smp_ready = 1'b1;
    if (udly == 0) begin
      pulse_upd();
    end else begin
      tick();
      smp_ready = 1'b0;
      repeat (udly - 1) tick();
      pulse_upd();
    end
    smp_ready = 1'b0;
    post_upd();
  endtask

  initial begin
    smp_t sa, sb, sc, s;
    in_valid_w1 = 0; in_valid_w2 = 0; in_valid_d = 0; in_valid_t = 0;
    weight1 = '0; weight2 = '0; data_point = '0; target = '0;
    smp_ready = 0; upd_valid = 0; upd_w1 = '0; upd_w2 = '0;
    mw1 = '0; mw2 = '0; nw1 = '0; nw2 = '0; n_upd = 0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_valid", smp_valid, 1'b0);
    chk("rst_done", train_done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_w1", w1_flat, '0);
    chk("rst_idx", {data_idx, epoch_idx}, '0);
    rst = 1'b0;
    tick();

    // weight load, ramp values
    load_weights(1'b1);
    chk("w1_load", w1_flat, mw1);
    chk("w2_load", w2_flat, mw2);
    chk("err_load", err, 1'b0);

    // first sample, target last, ready already high
    sa = rand_smp();
    sa.t = 32'h40000000;
    smp_ready = 1'b1;
    load_sample(sa, N_IN);
    chk("lat_1", smp_valid, 1'b0);
    tick();
    chk("lat_2", smp_valid, 1'b1);
    chk("smp_data_a", smp_data, sa.d);
    chk("smp_tgt_a", smp_target, sa.t);
    chk("idx_a", data_idx, 0);
    tick();
    smp_ready = 1'b0;
    chk("vld_after_acc", smp_valid, 1'b0);
    tick();
    pulse_upd();
    post_upd();

    // back-pressure while next sample stages; overflow word must be dropped
    sb = rand_smp();
    load_sample(sb, N_IN);
    tick();
    chk("smp_valid_b", smp_valid, 1'b1);
    sc = rand_smp();
    load_sample(sc, $urandom_range(0, N_IN));
    tick();
    chk("hold_valid_b", smp_valid, 1'b1);
    chk("hold_data_b", smp_data, sb.d);
    chk("err_before_ovf", err, 1'b0);
    in_valid_d = 1'b1;
    data_point = 32'hDEADBEEF;
    tick();
    in_valid_d = 1'b0;
    chk("err_ovf", err, 1'b1);
    accept_update(0, 0);
    wait_valid();
    chk("smp_data_c", smp_data, sc.d);
    chk("smp_tgt_c", smp_target, sc.t);
    accept_update(1, 2);
    chk("epoch_wrap", epoch_idx, 1);

    // asynchronous reset in the middle of a sample
    in_valid_d = 1'b1;
    data_point = $urandom;
    tick();
    data_point = $urandom;
    tick();
    in_valid_d = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", smp_valid, 1'b0);
    chk("arst_data", smp_data, '0);
    chk("arst_w", {w1_flat, w2_flat}, '0);
    chk("arst_idx", {data_idx, epoch_idx}, '0);
    chk("arst_err", err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    mw1 = '0; mw2 = '0; n_upd = 0;

    // full training run with random overlap and handshake timing
    load_weights(1'b0);
    chk("w1_reload", w1_flat, mw1);
    chk("w2_reload", w2_flat, mw2);
    s = rand_smp();
    load_sample(s, $urandom_range(0, N_IN));
    for (int k = 0; k < DS * EP; k++) begin
      wait_valid();
      chk("run_data", smp_data, q[0].d);
      chk("run_tgt", smp_target, q[0].t);
      chk("run_idx", data_idx, n_upd % DS);
      chk("run_epoch", epoch_idx, n_upd / DS);
      if (k < DS * EP - 1) begin
        s = rand_smp();
        load_sample(s, $urandom_range(0, N_IN));
      end
      accept_update($urandom_range(0, 2), $urandom_range(0, 2));
    end
    chk("run_err", err, 1'b0);

    // stray write-back with nothing outstanding
    for (int i = 0; i < W1_N; i++) upd_w1[i*DW +: DW] = $urandom;
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    chk("stray_w1", w1_flat, mw1);
    chk("stray_err", err, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/nn_train_sequencer.md
Name: nn_train_sequencer

Overview:
- Parametrised front-end for the floating-point NN training core: collects weight1/weight2 streams and per-sample data/target streams, then hands each assembled sample to the compute core over a valid/ready handshake.
- Tracks dataset index and epoch, applies weight write-back from the core, and flags end of training.
- Generalises the fixed-size NN input interface to arbitrary layer sizes, float format, dataset size and epoch count.
- Adds a one-deep staging buffer so the next sample loads while the current one trains.

Parameters:
SIG_W  23  float significand width (DW = SIG_W+EXP_W+1)
EXP_W  8  float exponent width
N_IN  4  input-layer width (data words per sample)
N_HID  3  hidden-layer width (weight1 = N_HID*N_IN words, weight2 = N_HID words)
EPOCH_MAX  25  number of epochs
DATASET_MAX  100  samples per epoch

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_valid_w1  in  1  weight1 word valid
weight1  in  DW  weight1 word, row-major [hid][in]
in_valid_w2  in  1  weight2 word valid
weight2  in  DW  weight2 word
in_valid_d  in  1  data word valid
data_point  in  DW  data word
in_valid_t  in  1  target valid
target  in  DW  target word
smp_valid  out  1  sample available to core
smp_ready  in  1  core accepts sample
smp_data  out  N_IN*DW  sample data, word 0 in LSBs
smp_target  out  DW  sample target
w1_flat  out  N_HID*N_IN*DW  current weight1 array
w2_flat  out  N_HID*DW  current weight2 array
upd_valid  in  1  core weight write-back strobe
upd_w1  in  N_HID*N_IN*DW  updated weight1
upd_w2  in  N_HID*DW  updated weight2
data_idx  out  clog2(DATASET_MAX)  index of sample in flight
epoch_idx  out  clog2(EPOCH_MAX)  current epoch
train_done  out  1  one-cycle pulse after final update
err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, any state): all outputs 0, weight arrays 0, both sample buffers empty, FSM IDLE, counters 0. Reset mid-training discards everything.
- FSM:
  - IDLE: goes to LOAD_W on first in_valid_w1 or in_valid_w2.
  - LOAD_W: w1 counter and w2 counter advance independently, one word per valid cycle. Streams may overlap or gap. Goes to RUN the cycle after both counts are complete.
  - RUN: issue/update loop.
  - DONE: asserts train_done for exactly 1 cycle, then IDLE.
- Sample load:
  - Data words fill the staging buffer in order.
  - in_valid_t may arrive in any cycle during or after the data words. It is captured once per sample.
  - Staging is full when N_IN data words and 1 target are held.
  - Loading is allowed in LOAD_W and RUN.
- Issue: when the active buffer is empty and staging is full, staging moves to active in 1 cycle.
  - smp_valid rises the next cycle and holds, with smp_data/smp_target stable, until the smp_valid && smp_ready cycle.
  - Latency from the last staging word to smp_valid is 2 cycles when the active buffer is idle.
- Update: after acceptance, the block waits for upd_valid. It may arrive in the acceptance cycle or later.
  - On upd_valid, w1/w2 load from upd_* and the active buffer frees.
  - data_idx increments. At DATASET_MAX-1 it wraps to 0 and epoch_idx increments.
  - Update of sample (DATASET_MAX-1, EPOCH_MAX-1) → DONE.
  - If upd_valid and a staging transfer fall in the same cycle, the transfer happens 1 cycle later. No sample is lost.
- err (sticky until reset) is set on any of:
  - data or target while staging is full (the word is dropped);
  - weight words beyond the expected count;
  - upd_valid with no accepted sample outstanding (ignored);
  - in_valid_d in IDLE.
- No arithmetic on float values; words are stored bit-exact.

Decomposition:
- Package nn_pkg: DW derivation, FSM state enum (IDLE, LOAD_W, RUN, DONE), and index-width localparams using clog2 with a minimum of 1.
- Sub-module nn_sample_buf: one instance each for the staging and active buffers. It holds N_IN+1 words with fill counter, full flag and load/clear controls.

Test Plan:
1. Default params: load 12 w1 words (0x3F800000+i) and 3 w2 words → w1_flat/w2_flat match bit-exact, FSM in RUN, err=0.
2. 4 data words then target 0x40000000, smp_ready=1 → smp_valid 2 cycles after target, smp_data matches, data_idx=0.
3. smp_ready held 0 for 5 cycles while the next sample loads → smp_data stable, staging full, extra data word sets err=1 and is dropped.
4. DATASET_MAX=3, EPOCH_MAX=2, immediate upd_valid per sample → data_idx 0,1,2,0,1,2; epoch_idx 0→1; train_done single pulse after the 6th update.
5. upd_valid with no outstanding sample → weights unchanged, err=1.
6. rst asserted mid-sample (2 of 4 words loaded) → all outputs 0 asynchronously; a fresh full load then trains normally.
